// File: rtl/peak_pkg.sv
// +------------------------------------------------------------------+
// | peak_pkg : shared defaults and width helpers for peak tracking   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package peak_pkg;

    localparam int DEF_NUM_CH   = 2;
    localparam int DEF_SAMPLE_W = 4;
    localparam int DEF_WINDOW   = 16;

    function automatic int ch_width(input int num_ch);
        return ($clog2(num_ch) > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int cnt_width(input int window);
        return $clog2(window + 1);
    endfunction

    localparam int DEF_CH_W  = ch_width(DEF_NUM_CH);
    localparam int DEF_CNT_W = cnt_width(DEF_WINDOW);

endpackage

`default_nettype wire

// File: rtl/peak_lane.sv
// +------------------------------------------------------------------+
// | peak_lane : per-channel sample counter and running maximum       |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module peak_lane
    import peak_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int WINDOW   = DEF_WINDOW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                hit,
    input  logic [SAMPLE_W-1:0] data,
    output logic                done,
    output logic [SAMPLE_W-1:0] max_next
);

    localparam int CNT_W = cnt_width(WINDOW);

    logic [CNT_W-1:0]    r_cnt;
    logic [SAMPLE_W-1:0] r_max;
    logic                w_first;
    logic                w_last;

    // The first sample of a window overwrites whatever the previous window left.
    assign w_first  = (r_cnt == '0);
    assign w_last   = (r_cnt == CNT_W'(WINDOW - 1));
    assign max_next = (w_first || (data > r_max)) ? data : r_max;
    assign done     = hit && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_max <= '0;
        end else if (clear) begin
            r_cnt <= '0;
            r_max <= '0;
        end else if (hit) begin
            r_cnt <= w_last ? '0 : (r_cnt + 1'b1);
            r_max <= max_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/peak_window_tracker.sv
// +------------------------------------------------------------------+
// | peak_window_tracker : per-channel windowed peak detector with a  |
// | single-entry valid/ready result register.             rev 1.0    |
// +------------------------------------------------------------------+
`default_nettype none

module peak_window_tracker
    import peak_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int WINDOW   = DEF_WINDOW,
    localparam int CH_W    = ch_width(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [CH_W-1:0]     s_chan,
    input  logic [SAMPLE_W-1:0] s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [CH_W-1:0]     m_chan,
    output logic [SAMPLE_W-1:0] m_max,
    output logic                err_chan
);

    logic                w_accept;
    logic                w_in_range;
    logic [NUM_CH-1:0]   w_hit;
    logic [NUM_CH-1:0]   w_done;
    logic [SAMPLE_W-1:0] w_lane_max [NUM_CH];
    logic                w_load;
    logic [CH_W-1:0]     w_load_chan;
    logic [SAMPLE_W-1:0] w_load_max;

    assign s_ready    = !m_valid || m_ready;
    // A sample arriving with clear is dropped, so clear masks the accept here.
    assign w_accept   = s_valid && s_ready && !clear;
    assign w_in_range = (32'(s_chan) < NUM_CH);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        assign w_hit[g] = w_accept && w_in_range && (s_chan == CH_W'(g));

        peak_lane #(
            .SAMPLE_W (SAMPLE_W),
            .WINDOW   (WINDOW)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear),
            .hit      (w_hit[g]),
            .data     (s_data),
            .done     (w_done[g]),
            .max_next (w_lane_max[g])
        );
    end

    // At most one lane is hit per cycle, so at most one done bit is set.
    always_comb begin
        w_load      = |w_done;
        w_load_chan = '0;
        w_load_max  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_done[c]) begin
                w_load_chan = CH_W'(c);
                w_load_max  = w_lane_max[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_chan  <= '0;
            m_max   <= '0;
        end else if (clear) begin
            m_valid <= 1'b0;
        end else if (w_load) begin
            m_valid <= 1'b1;
            m_chan  <= w_load_chan;
            m_max   <= w_load_max;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_chan <= 1'b0;
        end else if (w_accept && !w_in_range) begin
            err_chan <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_peak_window_tracker.sv
// +------------------------------------------------------------------+
// | tb_peak_window_tracker : directed self-checking bench            |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_peak_window_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       s_valid;
    logic       s_ready;
    logic       s_chan;
    logic [3:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_chan;
    logic [3:0] m_max;
    logic       err_chan;

    logic       s3_valid;
    logic       s3_ready;
    logic [1:0] s3_chan;
    logic [3:0] s3_data;
    logic       m3_valid;
    logic       m3_ready;
    logic [1:0] m3_chan;
    logic [3:0] m3_max;
    logic       err3;

    int         n_vec = 0;
    int         n_err = 0;
    logic [4:0] got_q [$];

    always #5 clk = ~clk;

    peak_window_tracker dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_chan   (s_chan),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_chan   (m_chan),
        .m_max    (m_max),
        .err_chan (err_chan)
    );

    peak_window_tracker #(.NUM_CH(3)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .s_valid  (s3_valid),
        .s_ready  (s3_ready),
        .s_chan   (s3_chan),
        .s_data   (s3_data),
        .m_valid  (m3_valid),
        .m_ready  (m3_ready),
        .m_chan   (m3_chan),
        .m_max    (m3_max),
        .err_chan (err3)
    );

    // Record every completed output handshake of the default instance.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) got_q.push_back({m_chan, m_max});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic ch, input logic [3:0] d);
        s_valid = 1'b1;
        s_chan  = ch;
        s_data  = d;
        step();
        s_valid = 1'b0;
    endtask

    task automatic send3(input logic [1:0] ch, input logic [3:0] d);
        s3_valid = 1'b1;
        s3_chan  = ch;
        s3_data  = d;
        step();
        s3_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic ch, input logic [3:0] mx);
        logic [4:0] r;
        check({tag, "_present"}, 32'(got_q.size() > 0), 1);
        if (got_q.size() > 0) begin
            r = got_q.pop_front();
            check({tag, "_chan"}, 32'(r[4]), 32'(ch));
            check({tag, "_max"}, 32'(r[3:0]), 32'(mx));
        end
    endtask

    task automatic expect_none(input string tag);
        check(tag, got_q.size(), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        s_valid  = 1'b0;
        s_chan   = 1'b0;
        s_data   = '0;
        m_ready  = 1'b1;
        s3_valid = 1'b0;
        s3_chan  = '0;
        s3_data  = '0;
        m3_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_chan", m_chan, 0);
        check("rst_m_max", m_max, 0);
        check("rst_err", err_chan, 0);
        rst_n = 1'b1;
        step();
        check("rst_s_ready", s_ready, 1);

        // Single ch0 window: 3, 9, then fourteen 1s
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("t1_no_early_valid", m_valid, 0);
            send(1'b0, (i == 0) ? 4'd3 : (i == 1) ? 4'd9 : 4'd1);
        end
        check("t1_valid", m_valid, 1);
        check("t1_chan", m_chan, 0);
        check("t1_max", m_max, 9);
        step();
        step();
        expect_result("t1", 1'b0, 4'd9);
        expect_none("t1_single");
        check("t1_drained", m_valid, 0);

        // Interleaved ch0/ch1, back-to-back completion
        for (int i = 0; i < 16; i++) begin
            send(1'b0, 4'(i % 8));
            send(1'b1, (i == 5) ? 4'd15 : 4'd3);
        end
        step();
        step();
        expect_result("t2_a", 1'b0, 4'd7);
        expect_result("t2_b", 1'b1, 4'd15);
        expect_none("t2_count");

        // Backpressure: result held, incoming sample ignored
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(1'b1, (i == 7) ? 4'd11 : 4'd4);
        check("t3_valid", m_valid, 1);
        check("t3_s_ready_low", s_ready, 0);
        s_valid = 1'b1;
        s_chan  = 1'b0;
        s_data  = 4'd15;
        for (int k = 0; k < 10; k++) begin
            step();
            check("t3_hold_valid", m_valid, 1);
            check("t3_hold_chan", m_chan, 1);
            check("t3_hold_max", m_max, 11);
            check("t3_hold_ready", s_ready, 0);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        #1;
        check("t3_ready_comb", s_ready, 1);
        step();
        step();
        expect_result("t3", 1'b1, 4'd11);
        for (int i = 0; i < 16; i++) send(1'b0, 4'd2);
        step();
        step();
        expect_result("t3_ignored", 1'b0, 4'd2);
        expect_none("t3_count");

        // Clear mid-window, with a competing sample that must be dropped
        for (int i = 0; i < 8; i++) send(1'b0, 4'd12);
        clear   = 1'b1;
        s_valid = 1'b1;
        s_chan  = 1'b0;
        s_data  = 4'd15;
        step();
        clear   = 1'b0;
        s_valid = 1'b0;
        check("t4_clear_valid", m_valid, 0);
        for (int i = 0; i < 16; i++) send(1'b0, 4'd2);
        step();
        step();
        expect_result("t4_clear", 1'b0, 4'd2);
        expect_none("t4_clear_count");

        // Asynchronous reset mid-window
        for (int i = 0; i < 8; i++) send(1'b0, 4'd12);
        rst_n = 1'b0;
        #1;
        check("t4_async_max", m_max, 0);
        check("t4_async_valid", m_valid, 0);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 16; i++) send(1'b0, 4'd2);
        step();
        step();
        expect_result("t4_rst", 1'b0, 4'd2);
        expect_none("t4_rst_count");

        // Final sample accepted on the same edge the pending result drains
        m_ready = 1'b0;
        for (int i = 0; i < 15; i++) send(1'b1, 4'd6);
        for (int i = 0; i < 16; i++) send(1'b0, 4'd5);
        check("t5_pending", m_valid, 1);
        check("t5_pending_chan", m_chan, 0);
        s_valid = 1'b1;
        s_chan  = 1'b1;
        s_data  = 4'd8;
        m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        check("t5_reload_valid", m_valid, 1);
        check("t5_reload_chan", m_chan, 1);
        check("t5_reload_max", m_max, 8);
        step();
        step();
        expect_result("t5_a", 1'b0, 4'd5);
        expect_result("t5_b", 1'b1, 4'd8);
        expect_none("t5_count");

        // Out-of-range tag on a 3-channel instance
        send3(2'd3, 4'd15);
        check("t6_err", err3, 1);
        check("t6_no_valid", m3_valid, 0);
        check("t6_s_ready", s3_ready, 1);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("t6_no_early_valid", m3_valid, 0);
            send3(2'd0, 4'd1);
        end
        check("t6_valid", m3_valid, 1);
        check("t6_chan", m3_chan, 0);
        check("t6_max", m3_max, 1);
        step();
        check("t6_err_sticky", err3, 1);
        check("t6_dut_err_clean", err_chan, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/peak_window_tracker.md
PEAK_WINDOW_TRACKER -- requirements
Module: peak_window_tracker

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of wavelength channels (ch0 = 730 nm, ch1 = 850 nm); legal range 2..16.
REQ-002 SHALL have parameter SAMPLE_W, default 4, unsigned amplitude width in bits; legal range 1..16.
REQ-003 SHALL have parameter WINDOW, default 16, samples per channel per window; legal range 2..1024.
REQ-004 SHALL derive CH_W = max(1, clog2(NUM_CH)) and CNT_W = clog2(WINDOW+1).
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port clear, input, 1, synchronous flush of all windows and any pending result.
REQ-008 SHALL have port s_valid, input, 1, sample present.
REQ-009 SHALL have port s_ready, output, 1, sample accepted this cycle when high together with s_valid.
REQ-010 SHALL have port s_chan, input, CH_W, channel tag of the sample.
REQ-011 SHALL have port s_data, input, SAMPLE_W, unsigned amplitude.
REQ-012 SHALL have port m_valid, output, 1, window result present.
REQ-013 SHALL have port m_ready, input, 1, result consumed when high together with m_valid.
REQ-014 SHALL have port m_chan, output, CH_W, channel of the result.
REQ-015 SHALL have port m_max, output, SAMPLE_W, window maximum.
REQ-016 SHALL have port err_chan, output, 1, sticky flag for an out-of-range tag.

Function
REQ-017 SHALL accept a sample only on a cycle where s_valid && s_ready, and ignore s_chan/s_data otherwise.
REQ-018 SHALL drive s_ready = !m_valid || m_ready, combinationally, giving a single-entry output register that can be refilled in the same cycle it is drained.
REQ-019 SHALL keep a per-channel count cnt[c] (0..WINDOW-1) and running maximum max[c].
REQ-020 On an accepted sample with cnt[c]==0, SHALL set max[c] to s_data; otherwise SHALL set max[c] to the unsigned maximum of max[c] and s_data; SHALL then increment cnt[c].
REQ-021 When an accepted sample brings cnt[c] to WINDOW, SHALL on the next edge:
- load m_max with the maximum including that sample,
- load m_chan with c,
- set m_valid to 1,
- reset cnt[c] to 0.
REQ-022 SHALL have a latency of exactly 1 cycle from the final sample's accept edge to m_valid high.
REQ-023 SHALL hold m_valid, m_chan and m_max stable while m_valid && !m_ready.
REQ-024 SHALL clear m_valid on the edge where m_valid && m_ready and no new result is loaded.
REQ-025 SHALL let a new load win over the drain when both occur in the same edge.
REQ-026 SHALL keep the windows of different channels independent; interleaved tags in any order are legal.
REQ-027 For a sample with s_chan >= NUM_CH, SHALL accept it (s_ready is unaffected), leave all channel state unchanged, and set err_chan until reset.
REQ-028 On clear, SHALL zero all cnt and max values and m_valid; clear SHALL take priority over a simultaneous accept or drain, and that sample SHALL be discarded.
REQ-029 SHALL treat equal samples as a maximum equal to that value; all-zero windows SHALL report m_max = 0.

Reset
REQ-030 While rst_n is low, SHALL asynchronously force cnt[*] = 0, max[*] = 0, m_valid = 0, m_chan = 0, m_max = 0 and err_chan = 0.
REQ-031 A reset mid-window SHALL discard partial windows; the first sample after rst_n rises SHALL start a fresh window.
REQ-032 SHALL have s_ready high while reset is released, with no result pending.

Structure
REQ-033 SHALL place the default NUM_CH/SAMPLE_W/WINDOW values and the clog2-derived width constants in a shared package, peak_pkg.
REQ-034 SHALL implement each channel's count/max state in one sub-module, peak_lane, instantiated NUM_CH times by generate; the top level SHALL hold only the tag decode and the output register.

Verification
REQ-035 Defaults, ch0 samples 3,9,1,…,1 (16 samples) -> exactly one m_valid, m_chan=0, m_max=9, one cycle after the 16th accept.
REQ-036 Alternating ch0/ch1 samples, 16 each, ch1 max 15 -> two results, ch0 first then ch1, with ch1 m_max=15.
REQ-037 m_ready held 0 when a result arrives -> s_ready low, m_* stable for 10 cycles; m_ready=1 -> drain, s_ready returns high the same cycle.
REQ-038 NUM_CH=3, tag 3 with value 15 -> err_chan=1, no channel max changes, no m_valid.
REQ-039 clear or rst_n low after 8 ch0 samples of value 12, then 16 samples of value 2 -> m_max=2.
REQ-040 Final sample of one window accepted in the same cycle the previous result is drained -> new result loaded, no bubble, nothing lost.
